// File: rtl/noc_params.sv
// Shared NoC router parameters and types: flit format, label encoding and
// the output-arbiter state encoding.
package noc_params;
  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_DEPTH = 4;
  localparam int VC_SIZE  = $clog2(VC_NUM);
  localparam int CREDIT_W = $clog2(VC_DEPTH + 1);
  localparam int PTR_W    = $clog2(PORT_NUM);
  localparam int DATA_W   = 16;

  typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2} flit_label_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [DATA_W-1:0]  data;
  } flit_t;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Port index a+k folded back into 0..PORT_NUM-1 (k < PORT_NUM).
  function automatic logic [PTR_W-1:0] port_add(input logic [PTR_W-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= PORT_NUM) s = s - PORT_NUM;
    return PTR_W'(s);
  endfunction
endpackage

// File: rtl/sw_out_arbiter_rr.sv
// Stateless PORT_NUM-way round-robin pick: the first eligible input at or
// after ptr wins. The caller owns and advances ptr.
module rr_arbiter
  import noc_params::*;
(
  input  logic [PORT_NUM-1:0] elig,
  input  logic [PTR_W-1:0]    ptr,
  output logic [PORT_NUM-1:0] gnt
);
  logic [PTR_W-1:0] idx;

  // Scan from farthest to nearest so the closest eligible port is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = PORT_NUM - 1; k >= 0; k--) begin
      idx = port_add(ptr, k);
      if (elig[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sw_out_arbiter.sv
// Per-output-port switch arbiter: wormhole lock from HEAD to TAIL, round-robin
// among HEAD requests, and per-VC downstream credit tracking.
module sw_out_arbiter
  import noc_params::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PORT_NUM-1:0]                req_i,
  input  flit_t [PORT_NUM-1:0]               flit_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_i,
  output logic [PORT_NUM-1:0]                gnt_o,
  output flit_t                              flit_o,
  output logic                               valid_o,
  output logic [VC_SIZE-1:0]                 vc_o,
  input  logic                               credit_i,
  input  logic [VC_SIZE-1:0]                 credit_vc_i,
  output logic                               locked_o,
  output logic                               err_o
);
  arb_state_t                         state;
  logic [PTR_W-1:0]                   ptr;
  logic [PTR_W-1:0]                   owner;
  logic [VC_SIZE-1:0]                 lock_vc;
  logic [VC_NUM-1:0][CREDIT_W-1:0]    credit;

  logic [PORT_NUM-1:0]                elig;
  logic [PORT_NUM-1:0]                rr_gnt;
  logic                               any_gnt;
  logic [PTR_W-1:0]                   gnt_idx;
  flit_t                              gnt_flit;
  logic [VC_SIZE-1:0]                 gnt_vc;
  logic                               err_nxt;

  always_comb begin
    elig    = '0;
    err_nxt = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (state == ARB_IDLE) begin
        if (req_i[i]) begin
          if (flit_i[i].flit_label != HEAD) err_nxt = 1'b1;
          else if (credit[vc_i[i]] != '0)   elig[i] = 1'b1;
        end
      end else if (req_i[i] && owner == PTR_W'(i)) begin
        // Non-owners are simply ignored while locked; only the owner can misbehave.
        if (flit_i[i].flit_label == HEAD) err_nxt = 1'b1;
        else if (credit[lock_vc] != '0)   elig[i] = 1'b1;
      end
    end
    if (credit_i && credit[credit_vc_i] == CREDIT_W'(VC_DEPTH) &&
        !(any_gnt && gnt_vc == credit_vc_i))
      err_nxt = 1'b1;
  end

  rr_arbiter u_rr (
    .elig (elig),
    .ptr  (ptr),
    .gnt  (rr_gnt)
  );

  // Reset is asynchronous, so the grant must also vanish the moment rst rises.
  assign gnt_o   = rst ? '0 : rr_gnt;
  assign any_gnt = |gnt_o;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < PORT_NUM; i++)
      if (gnt_o[i]) gnt_idx = PTR_W'(i);
  end

  assign gnt_flit = flit_i[gnt_idx];
  assign gnt_vc   = (state == ARB_IDLE) ? vc_i[gnt_idx] : lock_vc;
  assign locked_o = (state == ARB_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      owner   <= '0;
      lock_vc <= '0;
      valid_o <= 1'b0;
      flit_o  <= '0;
      vc_o    <= '0;
      err_o   <= 1'b0;
      for (int v = 0; v < VC_NUM; v++) credit[v] <= CREDIT_W'(VC_DEPTH);
    end else begin
      err_o   <= err_nxt;
      valid_o <= any_gnt;
      if (any_gnt) begin
        flit_o <= gnt_flit;
        vc_o   <= gnt_vc;
      end
      case (state)
        ARB_IDLE: if (any_gnt) begin
          state   <= ARB_LOCKED;
          owner   <= gnt_idx;
          lock_vc <= gnt_vc;
          ptr     <= port_add(gnt_idx, 1);
        end
        ARB_LOCKED: if (any_gnt && gnt_flit.flit_label == TAIL) state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
      for (int v = 0; v < VC_NUM; v++) begin
        if (any_gnt && gnt_vc == VC_SIZE'(v)) begin
          if (!(credit_i && credit_vc_i == VC_SIZE'(v))) credit[v] <= credit[v] - 1'b1;
        end else if (credit_i && credit_vc_i == VC_SIZE'(v) &&
                     credit[v] != CREDIT_W'(VC_DEPTH)) begin
          credit[v] <= credit[v] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sw_out_arbiter.sv
// Directed bench for sw_out_arbiter: stimulus pushes expected forwarded flits
// into a scoreboard that an independent output monitor drains and compares.
module tb_sw_out_arbiter;
  import noc_params::*;

  logic                             clk = 1'b0;
  logic                             rst = 1'b1;
  logic [PORT_NUM-1:0]              req = '0;
  flit_t [PORT_NUM-1:0]             flits = '0;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] vcs = '0;
  logic [PORT_NUM-1:0]              gnt_o;
  flit_t                            flit_o;
  logic                             valid_o;
  logic [VC_SIZE-1:0]               vc_o;
  logic                             credit_in = 1'b0;
  logic [VC_SIZE-1:0]               credit_vc = '0;
  logic                             locked_o;
  logic                             err_o;

  sw_out_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .flit_i      (flits),
    .vc_i        (vcs),
    .gnt_o       (gnt_o),
    .flit_o      (flit_o),
    .valid_o     (valid_o),
    .vc_o        (vc_o),
    .credit_i    (credit_in),
    .credit_vc_i (credit_vc),
    .locked_o    (locked_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    flit_t              flit;
    logic [VC_SIZE-1:0] vc;
    int                 due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] dctr = 16'h0100;
  flit_label_t lab [PORT_NUM];
  logic [4:0]  fair_gnt [8] = '{5'b00001, 5'b00001, 5'b00010, 5'b00010,
                                5'b10000, 5'b10000, 5'b00001, 5'b00001};
  int          fair_ptr [8] = '{1, 1, 2, 2, 0, 0, 1, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Output monitor: every valid_o must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_valid: got flit %0h, expected no output", flit_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("flit_o", 32'(flit_o), 32'(e.flit));
          chk("vc_o", 32'(vc_o), 32'(e.vc));
          chk("latency", cyc, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        n_cmp++; n_err++;
        $display("FAIL missing_valid: got valid_o=0, expected flit %0h", sb[0].flit);
        void'(sb.pop_front());
      end
    end
  end

  task automatic offer(input int p, input flit_label_t l, input logic [VC_SIZE-1:0] v);
    req[p]              = 1'b1;
    flits[p].flit_label = l;
    flits[p].data       = dctr;
    vcs[p]              = v;
    dctr++;
  endtask

  task automatic clr();
    req       = '0;
    credit_in = 1'b0;
  endtask

  // One cycle: check grant and the registered error seen this cycle, and queue
  // the flit that the expected grant forwards.
  task automatic tick(input logic [4:0] eg, input logic [VC_SIZE-1:0] evc, input logic eerr);
    exp_t e;
    @(negedge clk);
    chk("gnt_o", 32'(gnt_o), 32'(eg));
    chk("err_o", 32'(err_o), 32'(eerr));
    for (int i = 0; i < PORT_NUM; i++)
      if (eg[i]) begin
        e.flit = flits[i];
        e.vc   = evc;
        e.due  = cyc + 1;
        sb.push_back(e);
      end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_flit", 32'(flit_o), 0);
    chk("rst_vc", 32'(vc_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_ptr", 32'(dut.ptr), 0);
    chk("rst_credit0", 32'(dut.credit[0]), VC_DEPTH);
    chk("rst_credit1", 32'(dut.credit[1]), VC_DEPTH);
    chk("rst_queue", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Basic packet on vc 1 from input 2.
    do_reset();
    offer(2, HEAD, 1'b1); tick(5'b00100, 1'b1, 1'b0);
    chk("basic_locked", 32'(locked_o), 1);
    offer(2, BODY, 1'b1); tick(5'b00100, 1'b1, 1'b0);
    offer(2, TAIL, 1'b1); tick(5'b00100, 1'b1, 1'b0);
    chk("basic_unlocked", 32'(locked_o), 0);
    chk("basic_credit1", 32'(dut.credit[1]), 1);
    clr(); tick(5'b00000, 1'b0, 1'b0);

    // Fairness: inputs 0, 1, 4 stream 2-flit packets on vc 0.
    do_reset();
    for (int i = 0; i < PORT_NUM; i++) lab[i] = HEAD;
    for (int k = 0; k < 8; k++) begin
      credit_in = (k > 0);
      credit_vc = 1'b0;
      offer(0, lab[0], 1'b0);
      offer(1, lab[1], 1'b0);
      offer(4, lab[4], 1'b0);
      tick(fair_gnt[k], 1'b0, 1'b0);
      for (int i = 0; i < PORT_NUM; i++)
        if (fair_gnt[k][i]) lab[i] = (lab[i] == HEAD) ? TAIL : HEAD;
      if (k % 2 == 0) chk("fair_ptr", 32'(dut.ptr), fair_ptr[k]);
    end
    clr();
    credit_in = 1'b1; tick(5'b00000, 1'b0, 1'b0);
    clr();
    chk("fair_credit0", 32'(dut.credit[0]), VC_DEPTH);

    // Lock exclusivity: input 3 owns the port while input 0 waits with a HEAD.
    do_reset();
    offer(3, HEAD, 1'b0); tick(5'b01000, 1'b0, 1'b0);
    offer(0, HEAD, 1'b1);
    offer(3, BODY, 1'b0); tick(5'b01000, 1'b0, 1'b0);
    tick(5'b01000, 1'b0, 1'b0);
    offer(3, TAIL, 1'b0); tick(5'b01000, 1'b0, 1'b0);
    req[3] = 1'b0;
    tick(5'b00001, 1'b1, 1'b0);
    offer(0, TAIL, 1'b1); tick(5'b00001, 1'b1, 1'b0);
    clr(); tick(5'b00000, 1'b0, 1'b0);

    // Credit stall on vc 0.
    do_reset();
    credit_vc = 1'b0;
    offer(1, HEAD, 1'b0); tick(5'b00010, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      offer(1, BODY, 1'b0); tick(5'b00010, 1'b0, 1'b0);
    end
    offer(1, TAIL, 1'b0); tick(5'b00000, 1'b0, 1'b0);
    tick(5'b00000, 1'b0, 1'b0);
    chk("stall_credit0", 32'(dut.credit[0]), 0);
    credit_in = 1'b1; tick(5'b00000, 1'b0, 1'b0);
    credit_in = 1'b0; tick(5'b00010, 1'b0, 1'b0);
    chk("stall_credit_after", 32'(dut.credit[0]), 0);
    clr();
    credit_in = 1'b1; tick(5'b00000, 1'b0, 1'b0);
    offer(1, HEAD, 1'b0); tick(5'b00010, 1'b0, 1'b0);
    credit_in = 1'b0;
    chk("simul_credit0", 32'(dut.credit[0]), 1);
    offer(1, TAIL, 1'b0); tick(5'b00010, 1'b0, 1'b0);
    chk("last_credit0", 32'(dut.credit[0]), 0);
    clr(); tick(5'b00000, 1'b0, 1'b0);

    // Protocol errors.
    do_reset();
    offer(2, BODY, 1'b0); tick(5'b00000, 1'b0, 1'b0);
    clr(); tick(5'b00000, 1'b0, 1'b1);
    tick(5'b00000, 1'b0, 1'b0);
    credit_in = 1'b1; credit_vc = 1'b1; tick(5'b00000, 1'b0, 1'b0);
    credit_in = 1'b0; tick(5'b00000, 1'b0, 1'b1);
    chk("sat_credit1", 32'(dut.credit[1]), VC_DEPTH);
    tick(5'b00000, 1'b0, 1'b0);
    offer(0, HEAD, 1'b0); tick(5'b00001, 1'b0, 1'b0);
    offer(0, HEAD, 1'b0); tick(5'b00000, 1'b0, 1'b0);
    offer(0, TAIL, 1'b0); tick(5'b00001, 1'b0, 1'b1);
    clr(); tick(5'b00000, 1'b0, 1'b0);

    // Reset in the middle of a packet.
    do_reset();
    offer(4, HEAD, 1'b1); tick(5'b10000, 1'b1, 1'b0);
    offer(4, BODY, 1'b1); tick(5'b10000, 1'b1, 1'b0);
    offer(4, TAIL, 1'b1);
    offer(2, HEAD, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(gnt_o), 0);
    chk("midrst_locked", 32'(locked_o), 0);
    chk("midrst_valid", 32'(valid_o), 0);
    chk("midrst_credit1", 32'(dut.credit[1]), VC_DEPTH);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    req[4] = 1'b0;
    tick(5'b00100, 1'b0, 1'b0);
    offer(2, TAIL, 1'b0); tick(5'b00100, 1'b0, 1'b0);
    clr(); tick(5'b00000, 1'b0, 1'b0);
    tick(5'b00000, 1'b0, 1'b0);
    chk("final_queue", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
